ex_stage_mdu: RTL
=================

Name: ex_stage_mdu

Overview:
Parametrised successor to the DLX pipeline EX stage. Performs the ALU op, computes the branch/jump target, and forwards operands from N younger stages. Adds a valid/ready handshake, load-use stall detection and an iterative multiply/divide unit (MDU) with a busy FSM. Sits between ID/EX registers and the MEM stage; drives the EX→MEM pipeline registers.

Parameters:
DATA_W, 32, datapath width (ALU instance is DATA_W wide, existing opcode map)
REG_AW, 5, register index width
FWD_N, 2, forwarding sources; index 0 = MEM (youngest), 1 = WB, ...

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  squash instruction in EX, abort MDU
mem_stall  in  1  MEM cannot accept; hold EX→MEM registers
ex_valid  in  1  ID/EX holds a valid instruction
ex_ready  out  1  instruction leaves EX this cycle if ex_valid
I_EX  in  5  ALU opcode
Iv_EX, S1_EX, S2_EX, PC_EX  in  DATA_W  immediate, rs1/rs2 values, PC
Rs1_EX, Rs2_EX, Rd_EX  in  REG_AW  register indices
Iv_alu_EX, Pc_alu_EX, Pc_add_EX, Pc_cmd_ex_EX  in  1  operand/branch selects (DLX meaning unchanged)
d_write_enable_EX, d_load_enable_EX  in  1  store/load
md_req_EX  in  1  instruction is an MDU op
md_op_EX  in  2  00 MUL lo, 01 MULH signed, 10 DIV signed, 11 REM signed
fwd_we  in  FWD_N  source k writes a register
fwd_ld  in  FWD_N  source k is a load (data not yet valid)
fwd_rd  in  FWD_N*REG_AW  destination of source k
fwd_data  in  FWD_N*DATA_W  result of source k
pc_cmd_EX  out  1  redirect PC
pc_in_EX  out  DATA_W  redirect target
md_busy  out  1  MDU iterating
valid_MEM, d_write_enable_MEM, d_load_enable_MEM  out  1  MEM controls
ALU_out_MEM, S2_MEM  out  DATA_W  result; forwarded store data
Rd_MEM, Rs2_MEM  out  REG_AW  indices

Behaviour:
- Reset: all *_MEM outputs 0, FSM=RUN, md_busy=0, MDU count=0.
- Forwarding (per operand): lowest k with fwd_we[k], fwd_rd[k]==Rs and Rs!=0 wins; else S1_EX/S2_EX.
- Load-use: winning source has fwd_ld[k]=1 → hazard; ex_ready=0 and no MDU start.
- ALU op1 = Pc_alu_EX ? PC_EX : fwd rs1; op2 = Iv_alu_EX ? Iv_EX : fwd rs2.
- pc_in_EX = Pc_add_EX ? PC_EX+Iv_EX : fwd rs1 (mod 2^DATA_W). pc_cmd_EX = ex_valid & ex_ready & Pc_cmd_ex_EX & !ZF; asserted only in the leaving cycle.
- FSM RUN: non-MDU op: ex_ready = !mem_stall & !hazard. MDU op with ex_valid & !hazard & !flush: latch operands and op, count=DATA_W, go to BUSY, ex_ready=0.
- FSM BUSY: md_busy=1; one radix-2 step per cycle; count decrements; at count==0 go to DONE.
- FSM DONE: result held; ex_ready = !mem_stall; on leave → RUN. Total MDU latency DATA_W+1 cycles with mem_stall low.
- Div by zero: quotient = all ones, remainder = dividend. MIN/−1: quotient = MIN, remainder = 0.
- EX→MEM registers load only when !mem_stall: valid_MEM <= ex_valid & ex_ready & !flush; other fields load the leaving instruction. Bubble cycles load valid_MEM=0, write/load enables=0.
- flush: same-cycle ex_ready forced 0 and pc_cmd_EX=0; FSM → RUN next edge; MDU result discarded.
- Reset mid-BUSY: returns to RUN immediately; nothing is forwarded to MEM.

Optional Feature:
EX_MDU_EN: defined → MDU and BUSY/DONE states present. Undefined → md_req_EX is ignored: op executes as a normal ALU op in one cycle, md_busy is tied 0, FSM RUN only.

Test Plan:
- ADD r3 with MEM fwd rd=3 data=0x10 and WB fwd rd=3 data=0x20; S1=5 → op1 uses 0x10; ALU_out_MEM = 0x10+op2 one cycle later.
- Load in MEM (fwd_ld[0]=1, rd=4), EX uses r4 → ex_ready=0 for 1 cycle, valid_MEM=0 bubble; next cycle WB data forwarded.
- DIV −7/2 (EX_MDU_EN) → md_busy high 32 cycles, ALU_out_MEM=0xFFFFFFFD after 33; REM → 0xFFFFFFFF; DIV 5/0 → 0xFFFFFFFF.
- BEQZ-style Pc_cmd_ex_EX=1, ZF=0, Pc_add_EX=1, PC=0x100, Iv=0x20 → pc_cmd_EX=1, pc_in_EX=0x120 for exactly one cycle; with mem_stall=1 → pc_cmd_EX=0 until release.
- flush at BUSY cycle 10 → md_busy=0 next cycle, valid_MEM=0, next instruction accepted.
- mem_stall held 3 cycles in DONE → *_MEM unchanged, result delivered on release.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// DLX-style EX stage: ALU, branch target, N-source operand forwarding, load-use stall.
// Define EX_MDU_EN to add the iterative radix-2 multiply/divide unit (RUN/BUSY/DONE FSM).
module ex_stage_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      mem_stall,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [4:0]                I_EX,
  input  logic [DATA_W-1:0]         Iv_EX,
  input  logic [DATA_W-1:0]         S1_EX,
  input  logic [DATA_W-1:0]         S2_EX,
  input  logic [DATA_W-1:0]         PC_EX,
  input  logic [REG_AW-1:0]         Rs1_EX,
  input  logic [REG_AW-1:0]         Rs2_EX,
  input  logic [REG_AW-1:0]         Rd_EX,
  input  logic                      Iv_alu_EX,
  input  logic                      Pc_alu_EX,
  input  logic                      Pc_add_EX,
  input  logic                      Pc_cmd_ex_EX,
  input  logic                      d_write_enable_EX,
  input  logic                      d_load_enable_EX,
  input  logic                      md_req_EX,
  input  logic [1:0]                md_op_EX,
  input  logic [FWD_N-1:0]          fwd_we,
  input  logic [FWD_N-1:0]          fwd_ld,
  input  logic [FWD_N*REG_AW-1:0]   fwd_rd,
  input  logic [FWD_N*DATA_W-1:0]   fwd_data,
  output logic                      pc_cmd_EX,
  output logic [DATA_W-1:0]         pc_in_EX,
  output logic                      md_busy,
  output logic                      valid_MEM,
  output logic                      d_write_enable_MEM,
  output logic                      d_load_enable_MEM,
  output logic [DATA_W-1:0]         ALU_out_MEM,
  output logic [DATA_W-1:0]         S2_MEM,
  output logic [REG_AW-1:0]         Rd_MEM,
  output logic [REG_AW-1:0]         Rs2_MEM
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  // Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
  // 8 SLT, 9 SLTU, 10 SEQ, 11 SNE, 12 pass op2, others 0.
  function automatic logic [DATA_W-1:0] alu_f(input logic [4:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [SH_W-1:0] sh;
    a_s = a;
    b_s = b;
    sh  = b[SH_W-1:0];
    case (op)
      5'd0:    alu_f = a + b;
      5'd1:    alu_f = a - b;
      5'd2:    alu_f = a & b;
      5'd3:    alu_f = a | b;
      5'd4:    alu_f = a ^ b;
      5'd5:    alu_f = a << sh;
      5'd6:    alu_f = a >> sh;
      5'd7:    alu_f = a_s >>> sh;
      5'd8:    alu_f = {{(DATA_W-1){1'b0}}, a_s < b_s};
      5'd9:    alu_f = {{(DATA_W-1){1'b0}}, a < b};
      5'd10:   alu_f = {{(DATA_W-1){1'b0}}, a == b};
      5'd11:   alu_f = {{(DATA_W-1){1'b0}}, a != b};
      5'd12:   alu_f = b;
      default: alu_f = '0;
    endcase
  endfunction

  logic [DATA_W-1:0] rs1_fwd, rs2_fwd, op1, op2, alu_res, ex_result;
  logic              ld1, ld2, hazard, zf, leave;

  // Iterate from the oldest source down so the youngest match overrides.
  always_comb begin
    rs1_fwd = S1_EX;
    rs2_fwd = S2_EX;
    ld1     = 1'b0;
    ld2     = 1'b0;
    for (int k = FWD_N - 1; k >= 0; k--) begin
      if (fwd_we[k] && Rs1_EX != '0 && fwd_rd[k*REG_AW +: REG_AW] == Rs1_EX) begin
        rs1_fwd = fwd_data[k*DATA_W +: DATA_W];
        ld1     = fwd_ld[k];
      end
      if (fwd_we[k] && Rs2_EX != '0 && fwd_rd[k*REG_AW +: REG_AW] == Rs2_EX) begin
        rs2_fwd = fwd_data[k*DATA_W +: DATA_W];
        ld2     = fwd_ld[k];
      end
    end
  end

  assign hazard    = ld1 | ld2;
  assign op1       = Pc_alu_EX ? PC_EX : rs1_fwd;
  assign op2       = Iv_alu_EX ? Iv_EX : rs2_fwd;
  assign alu_res   = alu_f(I_EX, op1, op2);
  assign zf        = (alu_res == '0);
  assign pc_in_EX  = Pc_add_EX ? (PC_EX + Iv_EX) : rs1_fwd;
  assign leave     = ex_valid & ex_ready;
  assign pc_cmd_EX = leave & Pc_cmd_ex_EX & ~zf;

`ifdef EX_MDU_EN
  typedef enum logic [1:0] {RUN, BUSY, DONE} md_state_t;

  md_state_t              state, state_nx;
  logic [CNT_W-1:0]       count;
  logic                   md_start;
  logic [1:0]             md_op_q;
  logic [DATA_W-1:0]      md_a, opb, acc_lo, step_lo;
  logic [DATA_W:0]        acc_hi, step_hi, mul_sum, r_sh;
  logic                   sign_a, neg_q, b_zero;

  function automatic logic [DATA_W-1:0] md_result_f(input logic [1:0] op,
                                                     input logic [DATA_W-1:0] hi,
                                                     input logic [DATA_W-1:0] lo,
                                                     input logic [DATA_W-1:0] dividend,
                                                     input logic neg_q_i,
                                                     input logic neg_r_i,
                                                     input logic b_zero_i);
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem;
    prod = {hi, lo};
    if (neg_q_i) prod = -prod;
    quo = neg_q_i ? -lo : lo;
    rem = neg_r_i ? -hi : hi;
    case (op)
      2'b00:   md_result_f = prod[DATA_W-1:0];
      2'b01:   md_result_f = prod[2*DATA_W-1:DATA_W];
      2'b10:   md_result_f = b_zero_i ? '1 : quo;
      default: md_result_f = b_zero_i ? dividend : rem;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_nx;
      if (md_start)           count <= CNT_W'(DATA_W);
      else if (state == BUSY) count <= count - CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    ex_ready = 1'b0;
    md_busy  = 1'b0;
    md_start = 1'b0;
    case (state)
      RUN: begin
        if (md_req_EX) begin
          if (ex_valid && !hazard && !flush) begin
            md_start = 1'b1;
            state_nx = BUSY;
          end
        end else begin
          ex_ready = !mem_stall && !hazard;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (count == CNT_W'(1)) state_nx = DONE;
      end
      DONE: begin
        ex_ready = !mem_stall;
        if (!mem_stall) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    if (flush) begin
      ex_ready = 1'b0;
      md_start = 1'b0;
      state_nx = RUN;
    end
  end

  // Multiply: shift-add on magnitudes; divide: restoring on magnitudes. Signs fixed at the end.
  always_comb begin
    mul_sum = acc_hi + (acc_lo[0] ? {1'b0, opb} : '0);
    r_sh    = {acc_hi[DATA_W-1:0], acc_lo[DATA_W-1]};
    if (!md_op_q[1]) begin
      step_hi = {1'b0, mul_sum[DATA_W:1]};
      step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end else if (r_sh >= {1'b0, opb}) begin
      step_hi = r_sh - {1'b0, opb};
      step_lo = {acc_lo[DATA_W-2:0], 1'b1};
    end else begin
      step_hi = r_sh;
      step_lo = {acc_lo[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (md_start) begin
      md_op_q <= md_op_EX;
      md_a    <= rs1_fwd;
      sign_a  <= rs1_fwd[DATA_W-1];
      neg_q   <= rs1_fwd[DATA_W-1] ^ rs2_fwd[DATA_W-1];
      b_zero  <= (rs2_fwd == '0);
      opb     <= rs2_fwd[DATA_W-1] ? -rs2_fwd : rs2_fwd;
      acc_lo  <= rs1_fwd[DATA_W-1] ? -rs1_fwd : rs1_fwd;
      acc_hi  <= '0;
    end else if (state == BUSY) begin
      acc_hi  <= step_hi;
      acc_lo  <= step_lo;
    end
  end

  assign ex_result = (state == DONE)
                   ? md_result_f(md_op_q, acc_hi[DATA_W-1:0], acc_lo, md_a, neg_q, sign_a, b_zero)
                   : alu_res;
`else
  logic unused_md;
  assign unused_md = ^{md_req_EX, md_op_EX};
  assign ex_ready  = !mem_stall && !hazard && !flush;
  assign md_busy   = 1'b0;
  assign ex_result = alu_res;
`endif

  // EX -> MEM pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_MEM          <= 1'b0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      ALU_out_MEM        <= '0;
      S2_MEM             <= '0;
      Rd_MEM             <= '0;
      Rs2_MEM            <= '0;
    end else if (!mem_stall) begin
      valid_MEM          <= leave;
      d_write_enable_MEM <= leave & d_write_enable_EX;
      d_load_enable_MEM  <= leave & d_load_enable_EX;
      ALU_out_MEM        <= ex_result;
      S2_MEM             <= rs2_fwd;
      Rd_MEM             <= Rd_EX;
      Rs2_MEM            <= Rs2_EX;
    end
  end

endmodule
